// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES round sequencer.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int RK_IDX_W  = 4;
  localparam int BLK_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // AES round count for a given key length in 32-bit words.
  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_iter_round_ctrl_if.sv
// Block-in / ciphertext-out valid/ready streams of the AES round sequencer.
interface aes_iter_round_ctrl_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_iter_round_ctrl.sv
// Sequencer for an iterative AES encryption core. One combinational round
// unit is reused for NR cycles; this block owns the state register, round
// counter and the round-key index into the external expanded-key store.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a plaintext block, rk_idx=0 for initial AddRoundKey
// ROUND | round unit active, rk_idx=round, last round when round==NR
// DONE  | ciphertext held on out_data until out_ready
module aes_iter_round_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 8,
  parameter int NR = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_iter_round_ctrl_if.slave bus,
  output logic [RK_IDX_W-1:0]  rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic [AES_BLK_W-1:0] rnd_state,
  output logic                 rnd_final,
  input  logic [AES_BLK_W-1:0] rnd_result,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt
);

  // Only legal AES key/round combinations; the 4-bit round counter relies on NR <= 14.
  if (NR != nr_for_nk(NK) || !(NK == 4 || NK == 6 || NK == 8)) begin : g_param_chk
    $error("aes_iter_round_ctrl: NK must be 4, 6 or 8 and NR must equal NK+6");
  end

  localparam logic [RK_IDX_W-1:0] NR_L = RK_IDX_W'(NR);

  aes_fsm_e               fsm_q, fsm_d;
  logic [RK_IDX_W-1:0]    round_q, round_d;
  logic [AES_BLK_W-1:0]   data_q, data_d;
  logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic                   accept;
  logic                   out_hs;
  logic                   last_round;

  // Everything visible outside is decoded from registered state only.
  assign last_round    = (round_q == NR_L);
  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.out_data  = data_q;
  assign busy          = (fsm_q == ROUND) || (fsm_q == DONE);
  assign rk_idx        = (fsm_q == ROUND) ? round_q : '0;
  assign rnd_final     = (fsm_q == ROUND) && last_round;
  assign rnd_state     = data_q;
  assign blk_cnt       = blk_cnt_q;

  // Next-state and round counter.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    accept  = 1'b0;
    out_hs  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          round_d = RK_IDX_W'(1);
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (last_round) begin
          round_d = '0;
          fsm_d   = DONE;
        end else begin
          round_d = round_q + RK_IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_hs = 1'b1;
          fsm_d  = IDLE;
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = '0;
      end
    endcase
  end

  // FSM and round counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
    end
  end

  // State register: initial AddRoundKey on accept, round unit output while iterating, held in DONE.
  always_comb begin
    data_d = data_q;
    if (accept) begin
      data_d = bus.in_data ^ rk_data;
    end else if (fsm_q == ROUND) begin
      data_d = rnd_result;
    end
  end

  // Cipher state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Completed-block counter, wraps naturally.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_hs) begin
      blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
    end
  end

  // Completed-block counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_round_ctrl.sv
// Testbench: three sequencers (NK=4/6/8) with behavioural round units and
// expanded-key stores; expected ciphertexts queued at issue, checked by a monitor.
module tb_aes_iter_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [2:0]   in_valid_v = '0;
  logic [383:0] in_data_v = '0;
  logic [2:0]   out_ready_v = '0;
  logic [767:0] key_v = '0;
  logic         stream_on = 1'b0;
  logic         rnd_rdy = 1'b0;

  logic [2:0]   in_ready_v, out_valid_v, busy_v, rnd_final_v, out_ready_obs_v;
  logic [383:0] out_data_v;
  logic [11:0]  rk_idx_v;
  logic [47:0]  blk_cnt_v;

  typedef struct {int inst; logic [127:0] ct;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;

  // ---------------- AES reference (FIPS-197) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d = {b, b};
    return d[15-k -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a[0] = b[4*c]; a[1] = b[4*c+1]; a[2] = b[4*c+2]; a[3] = b[4*c+3];
        b[4*c]   = gmul(8'h02, a[0]) ^ gmul(8'h03, a[1]) ^ a[2] ^ a[3];
        b[4*c+1] = a[0] ^ gmul(8'h02, a[1]) ^ gmul(8'h03, a[2]) ^ a[3];
        b[4*c+2] = a[0] ^ a[1] ^ gmul(8'h02, a[2]) ^ gmul(8'h03, a[3]);
        b[4*c+3] = gmul(8'h03, a[0]) ^ a[1] ^ a[2] ^ gmul(8'h02, a[3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  // Round key r lives at [r*128 +: 128]; key words taken from the top of key256.
  function automatic logic [1919:0] key_expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [1919:0] flat = '0;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) flat[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return flat;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                               input int nk);
    logic [1919:0] rks = key_expand(key, nk);
    logic [127:0] s = pt ^ rks[127:0];
    for (int r = 1; r <= nk + 6; r++) s = aes_round(s, rks[r*128 +: 128], r == nk + 6);
    return s;
  endfunction

  // ---------------- DUT instances with environment ----------------
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NK = 4 + 2*g;
    localparam int NR = NK + 6;
    aes_iter_round_ctrl_if ifc();
    logic [3:0]    rk_idx;
    logic [127:0]  rk_data, rnd_state, rnd_result;
    logic          rnd_final, busy;
    logic [15:0]   blk_cnt;
    logic [1919:0] rk_flat;

    assign ifc.in_valid  = in_valid_v[g];
    assign ifc.in_data   = in_data_v[g*128 +: 128];
    assign ifc.out_ready = (g == 2 && stream_on) ? rnd_rdy : out_ready_v[g];
    assign rk_flat       = key_expand(key_v[g*256 +: 256], NK);
    assign rk_data       = (int'(rk_idx) <= NR) ? rk_flat[rk_idx*128 +: 128] : '0;
    assign rnd_result    = aes_round(rnd_state, rk_data, rnd_final);

    assign in_ready_v[g]           = ifc.in_ready;
    assign out_valid_v[g]          = ifc.out_valid;
    assign out_ready_obs_v[g]      = ifc.out_ready;
    assign busy_v[g]               = busy;
    assign rnd_final_v[g]          = rnd_final;
    assign out_data_v[g*128 +: 128] = ifc.out_data;
    assign rk_idx_v[g*4 +: 4]      = rk_idx;
    assign blk_cnt_v[g*16 +: 16]   = blk_cnt;

    aes_iter_round_ctrl #(.NK(NK), .NR(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (ifc),
      .rk_idx     (rk_idx),
      .rk_data    (rk_data),
      .rnd_state  (rnd_state),
      .rnd_final  (rnd_final),
      .rnd_result (rnd_result),
      .busy       (busy),
      .blk_cnt    (blk_cnt)
    );
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send(input int g, input logic [127:0] pt);
    int n = 0;
    logic acc = 1'b0;
    exp_q.push_back('{g, aes_encrypt(pt, key_v[g*256 +: 256], 4 + 2*g)});
    in_data_v[g*128 +: 128] = pt;
    in_valid_v[g] = 1'b1;
    while (!acc && n < 400) begin
      @(negedge clk);
      acc = in_ready_v[g];
      @(posedge clk); #1;
      n++;
    end
    in_valid_v[g] = 1'b0;
    chk($sformatf("send_accept_inst%0d", g), acc, 1'b1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(input int g, input int budget);
    int n = 0;
    while (!out_valid_v[g] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("out_valid_reached_inst%0d", g), out_valid_v[g], 1'b1);
  endtask

  task automatic chk_reset_state(input int g, input string tag);
    chk($sformatf("%s_inst%0d {in_ready,busy,out_valid,blk_cnt,rk_idx}", tag, g),
        {in_ready_v[g], busy_v[g], out_valid_v[g], blk_cnt_v[g*16 +: 16], rk_idx_v[g*4 +: 4]},
        {1'b1, 1'b0, 1'b0, 16'h0000, 4'h0});
  endtask

  task automatic kat(input int g, input logic [127:0] ct);
    int n = 1;
    int nr = 4 + 2*g + 6;
    logic seq_ok = 1'b1;
    out_ready_v[g] = 1'b1;
    send(g, PT_KAT);
    while (!out_valid_v[g] && n < 40) begin
      if (rk_idx_v[g*4 +: 4] != n[3:0] || rnd_final_v[g] != (n == nr)) seq_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("kat_latency_edges_inst%0d", g), n, nr + 1);
    chk($sformatf("kat_rk_idx_rnd_final_seq_inst%0d", g), seq_ok, 1'b1);
    chk($sformatf("kat_ciphertext_inst%0d", g), out_data_v[g*128 +: 128], ct);
    chk($sformatf("kat_rk_idx_done_inst%0d", g), rk_idx_v[g*4 +: 4], 4'h0);
    @(posedge clk); #1;
    chk($sformatf("kat_blk_cnt_inst%0d", g), blk_cnt_v[g*16 +: 16], 16'd1);
    chk($sformatf("kat_back_idle_inst%0d", g), {in_ready_v[g], out_valid_v[g]}, 2'b10);
    drain(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, pt2, ct;
    logic ok;
    int n;

    key_v[0   +: 256] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    key_v[256 +: 256] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    key_v[512 +: 256] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          for (int g = 0; g < 3; g++) begin
            if (out_valid_v[g] && out_ready_obs_v[g]) begin
              checks++;
              if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_output inst=%0d got=%h expected=none",
                         g, out_data_v[g*128 +: 128]);
              end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.inst != g || mon_e.ct !== out_data_v[g*128 +: 128]) begin
                  failures++;
                  $display("FAIL sb_ciphertext inst=%0d got=%h expected=%h (from inst %0d)",
                           g, out_data_v[g*128 +: 128], mon_e.ct, mon_e.inst);
                end
              end
            end
          end
        end
      end
      forever begin
        @(posedge clk); #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
      end
    join_none

    for (int g = 0; g < 3; g++) chk_reset_state(g, "reset");

    kat(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    kat(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    kat(2, 128'h8ea2b7ca516745bfeafc49904b496089);

    // Backpressure on NK=8: hold DONE for 20 cycles with spurious in_valid pulses.
    out_ready_v[2] = 1'b0;
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    ct = aes_encrypt(pt, key_v[512 +: 256], 8);
    send(2, pt);
    wait_out_valid(2, 40);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid_v[2] = i[0];
      in_data_v[256 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      if (out_data_v[256 +: 128] !== ct || !out_valid_v[2] || in_ready_v[2] || !busy_v[2])
        ok = 1'b0;
    end
    chk("bp_hold_stable", ok, 1'b1);
    chk("bp_blk_cnt_held", blk_cnt_v[32 +: 16], 16'd1);
    pt2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_q.push_back('{2, aes_encrypt(pt2, key_v[512 +: 256], 8)});
    in_data_v[256 +: 128] = pt2;
    in_valid_v[2] = 1'b1;
    out_ready_v[2] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_blk_cnt", blk_cnt_v[32 +: 16], 16'd2);
    chk("bp_release_idle", {in_ready_v[2], out_valid_v[2], busy_v[2]}, 3'b100);
    @(posedge clk); #1;
    in_valid_v[2] = 1'b0;
    chk("bp_next_accept", {in_ready_v[2], busy_v[2], rk_idx_v[8 +: 4]}, {1'b0, 1'b1, 4'h1});
    drain(40);

    // Reset in the middle of round 5; the in-flight block is dropped.
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(2, pt);
    n = 0;
    while (rk_idx_v[8 +: 4] != 4'd5 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reset_reached_round5", rk_idx_v[8 +: 4], 4'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk_reset_state(2, "mid_reset");
    repeat (20) @(posedge clk);
    #1;
    chk("mid_reset_no_output", {out_valid_v[2], blk_cnt_v[32 +: 16]}, 17'h0);
    send(2, PT_KAT);
    wait_out_valid(2, 40);
    chk("mid_reset_fresh_ct", out_data_v[256 +: 128], 128'h8ea2b7ca516745bfeafc49904b496089);
    drain(10);
    chk("mid_reset_fresh_blk_cnt", blk_cnt_v[32 +: 16], 16'd1);

    // Streaming: 100 random blocks with random out_ready.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_state(2, "pre_stream_reset");
    stream_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge clk); #1;
      end
      send(2, {$urandom(), $urandom(), $urandom(), $urandom()});
    end
    drain(3000);
    stream_on = 1'b0;
    @(posedge clk); #1;
    chk("stream_blk_cnt", blk_cnt_v[32 +: 16], 16'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
